tremor_extractor: RTL and testbench
===================================

// Module: tremor_extractor
// PURPOSE
//  Downstream stage of move_average_filter. Captures each raw sample at startFlag and waits for the filter's endFlag.
//  Then computes tremor = raw - moving_average, which is the high-pass tremor component.
//  Results are buffered in a small FIFO toward the host interface with a valid/ready handshake.
//  Also tracks the peak-to-peak tremor amplitude over a fixed number of samples.
// PARAMETERS
//  BIT_WIDTH    16  width of raw sample, filter average and tremor result (signed two's complement)
//  FIFO_DEPTH   8   result FIFO entries; power of two, >=2
//  WINDOW_SIZE  64  samples per amplitude window; >=2
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous reset, active-high
//  startFlag    in   1          1-cycle pulse, same pulse that starts move_average_filter
//  din          in   BIT_WIDTH  raw sample, valid in the startFlag cycle
//  aveData      in   BIT_WIDTH  filter dout, valid in the aveEndFlag cycle
//  aveEndFlag   in   1          filter endFlag, 1-cycle pulse
//  tremorData   out  BIT_WIDTH  FIFO head, signed tremor sample
//  tremorValid  out  1          FIFO non-empty
//  tremorReady  in   1          consumer accepts; pop when tremorValid && tremorReady
//  ampData      out  BIT_WIDTH  last window's max-min (unsigned, saturated)
//  ampValid     out  1          1-cycle pulse when ampData updates
//  overflow     out  1          sticky: a result was dropped because the FIFO was full
//  clrOverflow  in   1          clears overflow; a same-cycle new drop wins (overflow stays 1)
// BEHAVIOUR
//  Reset (rst=1 at an edge): FSM=IDLE, FIFO empty; all outputs 0, including tremorData.
//   Reset is honoured mid-operation: pending raw sample and partial window are discarded.
//  FSM: IDLE -startFlag-> WAIT_AVE (latch rawHold<=din).
//   WAIT_AVE -aveEndFlag-> CALC (latch aveHold<=aveData).
//   CALC -> IDLE after 1 cycle (result written to FIFO).
//  Restart: startFlag in WAIT_AVE or CALC re-latches rawHold and goes to WAIT_AVE.
//   In CALC the current result is still written first.
//  aveEndFlag in IDLE is ignored.
//  startFlag and aveEndFlag in the same cycle in WAIT_AVE:
//   the result is computed with the old rawHold, then the new sample is pending.
//  Arithmetic: diff = sext(rawHold) - sext(aveHold), BIT_WIDTH+1 bits.
//   The result saturates to [-2^(BW-1), 2^(BW-1)-1].
//  Latency: aveEndFlag at cycle N -> FIFO write at N+1 -> tremorValid=1 at N+2 (FIFO previously empty).
//  FIFO: registered head.
//   Write with FIFO full and no pop in the same cycle: result dropped, overflow<=1.
//   Full with a pop in the same cycle: the write is accepted.
//   Empty: tremorReady is ignored. Pointers wrap modulo FIFO_DEPTH.
//  Amplitude: on every FIFO write attempt (dropped or not), update winMax/winMin and increment sampleCnt.
//   On the WINDOW_SIZE-th sample: ampData <= sat(winMax - winMin) in BIT_WIDTH bits, unsigned, clipped to 2^BW-1.
//   ampValid pulses 1 cycle, at the cycle after the write.
//   winMax/winMin then reload from the next sample; sampleCnt wraps to 0.
// CONFIGURATION
//  TREMOR_AMP_EN defined: amplitude tracker is built as described.
//  TREMOR_AMP_EN undefined: no tracker logic; ampData tied to 0, ampValid tied to 0.
//   Tremor path and FIFO are unchanged.
// STRUCTURE
//  Package tremor_pkg: state_t enum {IDLE, WAIT_AVE, CALC}.
//   Also holds function sat_signed(diff) -> BIT_WIDTH, and localparam for the FIFO pointer width.
//  Sub-module tremor_fifo: synchronous FIFO (BIT_WIDTH, FIFO_DEPTH) with wr_en/full/rd_en/empty.
//   The parent handles overflow.
//  Top module holds the FSM, subtract/saturate, the amplitude tracker and the overflow flag.
// TESTING (BIT_WIDTH=16, FIFO_DEPTH=4, WINDOW_SIZE=4, TREMOR_AMP_EN defined unless noted)
//  1 din=100 @start, aveData=40 @aveEndFlag, ready=1 -> tremorData=60, tremorValid at N+2 for 1 cycle.
//  2 din=-32768, aveData=32767 -> tremorData=-32768 (saturated).
//    din=32767, aveData=-100 -> 32767.
//  3 ready=0, 5 results -> 4 buffered, 5th dropped, overflow=1.
//    Then ready=1 -> 4 values pop in order; clrOverflow -> 0.
//  4 tremor sequence 10,-20,35,5 -> ampValid pulse, ampData=55.
//    Next window 0,0,0,0 -> ampData=0.
//    Rebuilt with TREMOR_AMP_EN undefined -> ampValid never rises.
//  5 startFlag twice before aveEndFlag (din=7, then 9; aveData=2) -> single result 7.
//  6 rst asserted in WAIT_AVE with 2 entries queued -> tremorValid=0 next cycle.
//    A later aveEndFlag (no startFlag) produces no output.

Source files
------------

// File: rtl/tremor_pkg.sv
// Shared types and helpers for the tremor extractor.
package tremor_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_AVE, CALC} state_t;

   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_PTR_W      = $clog2(DEF_FIFO_DEPTH);

   // Clip a widened difference into the signed range of a bw-bit word (bw <= 32).
   function automatic logic [31:0] sat_signed(input logic signed [32:0] diff, input int bw);
      logic signed [32:0] hi, lo;
      hi = (33'sd1 <<< (bw - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (bw - 1));
      if (diff > hi)      return hi[31:0];
      else if (diff < lo) return lo[31:0];
      else                return diff[31:0];
   endfunction
endpackage

// File: rtl/tremor_fifo.sv
// Synchronous FIFO with registered storage; the head is read straight from the array.
module tremor_fifo
   import tremor_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]             cnt_q, cnt_d;
   logic                    do_wr, do_rd;

   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_rd    = rd_en && !empty;
      // A full FIFO still takes a write when the head leaves in the same cycle.
      do_wr    = wr_en && (!full || do_rd);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_wr && !do_rd)      cnt_d = cnt_q + (PW+1)'(1);
      else if (!do_wr && do_rd) cnt_d = cnt_q - (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/tremor_extractor.sv
// Raw-minus-average tremor extraction, result FIFO, overflow flag and peak-to-peak tracker.
// Define TREMOR_AMP_EN to build the amplitude tracker; otherwise ampData/ampValid are tied to 0.
module tremor_extractor
   import tremor_pkg::*;
#(
   parameter int BIT_WIDTH   = 16,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int WINDOW_SIZE = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 startFlag,
   input  logic [BIT_WIDTH-1:0] din,
   input  logic [BIT_WIDTH-1:0] aveData,
   input  logic                 aveEndFlag,
   output logic [BIT_WIDTH-1:0] tremorData,
   output logic                 tremorValid,
   input  logic                 tremorReady,
   output logic [BIT_WIDTH-1:0] ampData,
   output logic                 ampValid,
   output logic                 overflow,
   input  logic                 clrOverflow
);
   localparam int BW = BIT_WIDTH;

   state_t               state_q, state_d;
   logic [BW-1:0]        raw_hold_q, raw_hold_d, ave_hold_q, ave_hold_d, pend_raw_q, pend_raw_d;
   logic                 pend_q, pend_d, overflow_q, overflow_d;
   logic                 wr_en, fifo_full, fifo_empty;
   logic signed [BW:0]   diff;
   logic [BW-1:0]        res;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (startFlag) state_d = WAIT_AVE;
         WAIT_AVE: if (aveEndFlag) state_d = CALC;
         CALC:     state_d = (startFlag || pend_q) ? WAIT_AVE : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en = (state_q == CALC);
   end

   // A start arriving with the average is parked so the current result keeps the old raw sample.
   always_comb begin
      raw_hold_d = raw_hold_q;
      ave_hold_d = ave_hold_q;
      pend_d     = pend_q;
      pend_raw_d = pend_raw_q;
      case (state_q)
         IDLE: if (startFlag) raw_hold_d = din;
         WAIT_AVE: begin
            if (aveEndFlag) begin
               ave_hold_d = aveData;
               if (startFlag) begin
                  pend_d     = 1'b1;
                  pend_raw_d = din;
               end
            end else if (startFlag) begin
               raw_hold_d = din;
            end
         end
         CALC: begin
            pend_d = 1'b0;
            if (startFlag)   raw_hold_d = din;
            else if (pend_q) raw_hold_d = pend_raw_q;
         end
         default: ;
      endcase
      diff = {raw_hold_q[BW-1], raw_hold_q} - {ave_hold_q[BW-1], ave_hold_q};
      res  = BW'(sat_signed(33'(diff), BW));
      overflow_d = overflow_q;
      if (wr_en && fifo_full && !tremorReady) overflow_d = 1'b1;
      else if (clrOverflow)                   overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         raw_hold_q <= '0;
         ave_hold_q <= '0;
         pend_raw_q <= '0;
         pend_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         raw_hold_q <= raw_hold_d;
         ave_hold_q <= ave_hold_d;
         pend_raw_q <= pend_raw_d;
         pend_q     <= pend_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow    = overflow_q;
   assign tremorValid = !fifo_empty;

   tremor_fifo #(.W(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (res),
      .full    (fifo_full),
      .rd_en   (tremorReady),
      .rd_data (tremorData),
      .empty   (fifo_empty)
   );

`ifdef TREMOR_AMP_EN
   localparam int CW = (WINDOW_SIZE > 2) ? $clog2(WINDOW_SIZE) : 1;

   logic signed [BW-1:0] win_max_q, win_max_d, win_min_q, win_min_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        amp_data_q, amp_data_d;
   logic                 amp_vld_q, amp_vld_d;
   logic [BW:0]          span;

   always_comb begin
      win_max_d  = win_max_q;
      win_min_d  = win_min_q;
      cnt_d      = cnt_q;
      amp_data_d = amp_data_q;
      amp_vld_d  = 1'b0;
      if (wr_en) begin
         if (cnt_q == '0) begin
            win_max_d = $signed(res);
            win_min_d = $signed(res);
         end else begin
            if ($signed(res) > win_max_q) win_max_d = $signed(res);
            if ($signed(res) < win_min_q) win_min_d = $signed(res);
         end
         cnt_d = cnt_q + CW'(1);
      end
      span = {win_max_d[BW-1], win_max_d} - {win_min_d[BW-1], win_min_d};
      if (wr_en && cnt_q == CW'(WINDOW_SIZE - 1)) begin
         amp_data_d = span[BW] ? '1 : span[BW-1:0];
         amp_vld_d  = 1'b1;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_max_q  <= '0;
         win_min_q  <= '0;
         cnt_q      <= '0;
         amp_data_q <= '0;
         amp_vld_q  <= 1'b0;
      end else begin
         win_max_q  <= win_max_d;
         win_min_q  <= win_min_d;
         cnt_q      <= cnt_d;
         amp_data_q <= amp_data_d;
         amp_vld_q  <= amp_vld_d;
      end
   end

   assign ampData  = amp_data_q;
   assign ampValid = amp_vld_q;
`else
   assign ampData  = '0;
   assign ampValid = 1'b0;
`endif
endmodule

// File: tb/tb_tremor_extractor.sv
// Directed bench for tremor_extractor: vector table plus hand-written multi-cycle sequences.
module tb_tremor_extractor;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        startFlag = 1'b0, aveEndFlag = 1'b0, tremorReady = 1'b0, clrOverflow = 1'b0;
   logic [15:0] din = '0, aveData = '0;
   logic [15:0] tremorData, ampData;
   logic        tremorValid, ampValid, overflow;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct { int din; int ave; int exp; } vec_t;
   vec_t vt[5];

`ifdef TREMOR_AMP_EN
   localparam bit AMP = 1'b1;
`else
   localparam bit AMP = 1'b0;
`endif

   tremor_extractor #(.BIT_WIDTH(16), .FIFO_DEPTH(4), .WINDOW_SIZE(4)) dut (
      .clk(clk), .rst(rst), .startFlag(startFlag), .din(din), .aveData(aveData),
      .aveEndFlag(aveEndFlag), .tremorData(tremorData), .tremorValid(tremorValid),
      .tremorReady(tremorReady), .ampData(ampData), .ampValid(ampValid),
      .overflow(overflow), .clrOverflow(clrOverflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sdata();
      return int'($signed(tremorData));
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // start, one idle cycle, aveEnd; returns one cycle after the FIFO write cycle
   task automatic do_txn(input int d, input int a);
      din = 16'(d); startFlag = 1'b1; step();
      startFlag = 1'b0; step();
      aveData = 16'(a); aveEndFlag = 1'b1; step();
      aveEndFlag = 1'b0; step();
   endtask

   task automatic amp_last(input int d, input int exp_amp);
      din = 16'(d); startFlag = 1'b1; step();
      startFlag = 1'b0; step();
      aveData = 16'd0; aveEndFlag = 1'b1; step();
      aveEndFlag = 1'b0;
      chk("amp_valid_early", int'(ampValid), 0);
      step();
      chk("amp_valid_pulse", int'(ampValid), AMP ? 1 : 0);
      chk("amp_data", int'(ampData), AMP ? exp_amp : 0);
      step();
      chk("amp_valid_drop", int'(ampValid), 0);
   endtask

   initial begin
      int exp3[4];
      vt[0] = '{100, 40, 60};
      vt[1] = '{-32768, 32767, -32768};
      vt[2] = '{32767, -100, 32767};
      vt[3] = '{-5, 10, -15};
      vt[4] = '{0, 0, 0};

      do_reset();
      chk("rst_valid", int'(tremorValid), 0);
      chk("rst_data", int'(tremorData), 0);
      chk("rst_amp", int'(ampData), 0);
      chk("rst_ampv", int'(ampValid), 0);
      chk("rst_ovf", int'(overflow), 0);

      // table: result value and N+1 / N+2 / N+3 valid timing with ready held high
      tremorReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = 16'(vt[i].din); startFlag = 1'b1; step();
         startFlag = 1'b0; step();
         aveData = 16'(vt[i].ave); aveEndFlag = 1'b1; step();
         aveEndFlag = 1'b0;
         chk($sformatf("vec%0d_valid_n1", i), int'(tremorValid), 0);
         step();
         chk($sformatf("vec%0d_valid_n2", i), int'(tremorValid), 1);
         chk($sformatf("vec%0d_data", i), sdata(), vt[i].exp);
         step();
         chk($sformatf("vec%0d_valid_n3", i), int'(tremorValid), 0);
      end

      // fill, overflow, drain in order, clear
      do_reset();
      tremorReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp3[k] = k * 11 + 1;
         do_txn(exp3[k], 0);
      end
      chk("fill_ovf", int'(overflow), 0);
      do_txn(45, 0);
      chk("drop_ovf", int'(overflow), 1);
      tremorReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d_valid", k), int'(tremorValid), 1);
         chk($sformatf("drain%0d_data", k), sdata(), exp3[k]);
         step();
      end
      chk("drain_empty", int'(tremorValid), 0);
      chk("ovf_sticky", int'(overflow), 1);
      clrOverflow = 1'b1; step();
      clrOverflow = 1'b0;
      chk("ovf_clear", int'(overflow), 0);

      // amplitude windows
      do_reset();
      do_txn(10, 0); do_txn(-20, 0); do_txn(35, 0);
      amp_last(5, 55);
      do_txn(0, 0); do_txn(0, 0); do_txn(0, 0);
      amp_last(0, 0);

      // double start before average: second raw sample wins
      do_reset();
      din = 16'd7; startFlag = 1'b1; step();
      din = 16'd9; step();
      startFlag = 1'b0; step();
      aveData = 16'd2; aveEndFlag = 1'b1; step();
      aveEndFlag = 1'b0; step();
      chk("restart_valid", int'(tremorValid), 1);
      chk("restart_data", sdata(), 7);
      step();
      chk("restart_single", int'(tremorValid), 0);

      // start together with aveEnd: old raw used now, new raw pending
      do_reset();
      din = 16'd50; startFlag = 1'b1; step();
      startFlag = 1'b0; step();
      din = 16'd80; aveData = 16'd20; startFlag = 1'b1; aveEndFlag = 1'b1; step();
      startFlag = 1'b0; aveEndFlag = 1'b0; step();
      chk("coinc_data1", sdata(), 30);
      step();
      chk("coinc_empty", int'(tremorValid), 0);
      aveData = 16'd10; aveEndFlag = 1'b1; step();
      aveEndFlag = 1'b0; step();
      chk("coinc_valid2", int'(tremorValid), 1);
      chk("coinc_data2", sdata(), 70);
      step();

      // reset mid-operation
      do_reset();
      tremorReady = 1'b0;
      do_txn(3, 1); do_txn(4, 1);
      chk("pre_rst_valid", int'(tremorValid), 1);
      din = 16'd5; startFlag = 1'b1; step();
      startFlag = 1'b0; rst = 1'b1; step();
      rst = 1'b0;
      chk("mid_rst_valid", int'(tremorValid), 0);
      chk("mid_rst_data", int'(tremorData), 0);
      aveData = 16'd1; aveEndFlag = 1'b1; step();
      aveEndFlag = 1'b0;
      repeat (3) step();
      chk("post_rst_noout", int'(tremorValid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
